re_control: RTL and testbench

Exposure/readout controller for a small image-sensor front end. It holds a user-adjustable exposure time and runs a full capture sequence on an init request: erase, expose, then a two-phase pixel readout with ADC strobes. It sits between the user controls (buttons, already debounced) and the sensor/ADC drive pins. It also exports its internal state for debug and bench observation.

---
 rtl/re_control_pkg.sv | 53 +++++
 rtl/re_readout_fsm.sv | 79 +++++++
 rtl/re_control.sv | 138 +++++++++++++
 tb/tb_re_control.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/re_control_pkg.sv
// re_control_pkg: shared encodings and defaults for the exposure/readout
// controller.
//   - main FSM and readout sub-FSM state encodings (fixed codes, exported on
//     debug pins, so the values must not change)
//   - exposure limits and reset default, plus readout sub-state duration
//   - small helpers describing the readout sequence order
package re_control_pkg;

  localparam int unsigned T_DEFAULT = 10;
  localparam int unsigned T_MIN     = 2;
  localparam int unsigned T_MAX     = 30;
  localparam int unsigned RD_CYCLES = 2;
  localparam int unsigned CT_W      = 5;

  typedef enum logic [1:0] {
    MAIN_IDLE     = 2'b00,
    MAIN_EXPOSURE = 2'b01,
    MAIN_READOUT  = 2'b10,
    MAIN_UNUSED   = 2'b11
  } main_state_t;

  typedef enum logic [2:0] {
    RD_INIT    = 3'b000,
    RD_NRE_1   = 3'b001,
    RD_ADC_1   = 3'b010,
    RD_NOTHING = 3'b011,
    RD_NRE_2   = 3'b100,
    RD_ADC_2   = 3'b101,
    RD_END     = 3'b110,
    RD_UNUSED  = 3'b111
  } rd_state_t;

  // Sub-states that last RD_CYCLES cycles; INIT and END last a single cycle.
  function automatic logic rd_is_timed(input rd_state_t s);
    return (s == RD_NRE_1) || (s == RD_ADC_1) || (s == RD_NOTHING) ||
           (s == RD_NRE_2) || (s == RD_ADC_2);
  endfunction

  function automatic rd_state_t rd_next(input rd_state_t s);
    rd_state_t n;
    case (s)
      RD_INIT:    n = RD_NRE_1;
      RD_NRE_1:   n = RD_ADC_1;
      RD_ADC_1:   n = RD_NOTHING;
      RD_NOTHING: n = RD_NRE_2;
      RD_NRE_2:   n = RD_ADC_2;
      RD_ADC_2:   n = RD_END;
      default:    n = RD_INIT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/re_readout_fsm.sv
// re_readout_fsm: two-phase pixel readout sequencer.
// Idles in INIT until start, then walks
//   INIT(1) NRE_1 ADC_1 NOTHING NRE_2 ADC_2 (RD_CYCLES each) END(1)
// and returns to INIT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle request to begin a readout
//   done       : high during the END cycle (sequence finishes on that edge)
//   nre_1      : row-1 readout enable, active low
//   nre_2      : row-2 readout enable, active low
//   adc        : ADC convert strobe, active high
//   state      : current sub-state code
//   timer      : cycle counter inside timed sub-states, 0 elsewhere
module re_readout_fsm
  import re_control_pkg::*;
#(
  parameter int unsigned RD_CYCLES = re_control_pkg::RD_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  output logic       nre_1,
  output logic       nre_2,
  output logic       adc,
  output logic [2:0] state,
  output logic [1:0] timer
);

  localparam logic [1:0] TIMER_LAST = 2'(RD_CYCLES - 1);

  rd_state_t  state_q;
  logic [1:0] timer_q;
  logic       running_q;

  // INIT doubles as the parked state: the start edge only arms the sequencer,
  // so INIT is visible for one cycle after the main FSM enters READOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RD_INIT;
      timer_q   <= '0;
      running_q <= 1'b0;
    end else if (!running_q) begin
      state_q <= RD_INIT;
      timer_q <= '0;
      if (start) begin
        running_q <= 1'b1;
      end
    end else if (state_q == RD_INIT) begin
      state_q <= RD_NRE_1;
      timer_q <= '0;
    end else if (state_q == RD_END) begin
      state_q   <= RD_INIT;
      timer_q   <= '0;
      running_q <= 1'b0;
    end else if (rd_is_timed(state_q)) begin
      if (timer_q == TIMER_LAST) begin
        timer_q <= '0;
        state_q <= rd_next(state_q);
      end else begin
        timer_q <= timer_q + 2'd1;
      end
    end else begin
      state_q   <= RD_INIT;
      timer_q   <= '0;
      running_q <= 1'b0;
    end
  end

  always_comb begin
    done  = running_q && (state_q == RD_END);
    nre_1 = (state_q != RD_NRE_1);
    nre_2 = (state_q != RD_NRE_2);
    adc   = (state_q == RD_ADC_1) || (state_q == RD_ADC_2);
    state = state_q;
    timer = timer_q;
  end

endmodule

// File: rtl/re_control.sv
// re_control: exposure/readout controller for a small image-sensor front end.
// Holds a user-adjustable exposure time and, on an init request, runs
// erase (idle) -> expose -> two-phase readout with ADC strobes.
// Ports:
//   IN_Clock        : system clock, rising edge
//   IN_Reset        : asynchronous active-low reset
//   IN_Init         : capture request, level, sampled in IDLE
//   IN_Exp_increase : exposure +1 request, rising-edge detected, IDLE only
//   IN_Exp_decrease : exposure -1 request, rising-edge detected, IDLE only
//   OUT_NRE_1/2     : row readout enables, active low
//   OUT_ADC         : ADC convert strobe
//   OUT_Expose      : exposure gate
//   OUT_Erase       : pixel erase (high in IDLE)
//   OUT_count_time  : current exposure setting
//   OUT_Main_FSM    : main state code
//   OUT_RD_FSM      : readout sub-state code
//   OUT_RD_timer    : readout sub-state cycle counter
module re_control
  import re_control_pkg::*;
#(
  parameter int unsigned T_DEFAULT = re_control_pkg::T_DEFAULT,
  parameter int unsigned T_MIN     = re_control_pkg::T_MIN,
  parameter int unsigned T_MAX     = re_control_pkg::T_MAX,
  parameter int unsigned RD_CYCLES = re_control_pkg::RD_CYCLES
) (
  input  logic       IN_Clock,
  input  logic       IN_Reset,
  input  logic       IN_Init,
  input  logic       IN_Exp_increase,
  input  logic       IN_Exp_decrease,
  output logic       OUT_NRE_1,
  output logic       OUT_NRE_2,
  output logic       OUT_ADC,
  output logic       OUT_Expose,
  output logic       OUT_Erase,
  output logic [4:0] OUT_count_time,
  output logic [1:0] OUT_Main_FSM,
  output logic [2:0] OUT_RD_FSM,
  output logic [1:0] OUT_RD_timer
);

  localparam logic [CT_W-1:0] CT_DEFAULT = CT_W'(T_DEFAULT);
  localparam logic [CT_W-1:0] CT_MIN     = CT_W'(T_MIN);
  localparam logic [CT_W-1:0] CT_MAX     = CT_W'(T_MAX);

  main_state_t     main_q;
  logic [CT_W-1:0] count_time_q;
  logic [CT_W-1:0] exp_cnt_q;
  logic            inc_q;
  logic            dec_q;
  logic            inc_edge;
  logic            dec_edge;
  logic            rd_start;
  logic            rd_done;

  always_comb begin
    inc_edge = IN_Exp_increase & ~inc_q;
    dec_edge = IN_Exp_decrease & ~dec_q;
    // Last exposure cycle: hand over to the readout sequencer on this edge.
    rd_start = (main_q == MAIN_EXPOSURE) && (exp_cnt_q <= CT_W'(1));
  end

  // Main FSM and exposure down-counter.
  always_ff @(posedge IN_Clock or negedge IN_Reset) begin
    if (!IN_Reset) begin
      main_q    <= MAIN_IDLE;
      exp_cnt_q <= '0;
    end else begin
      case (main_q)
        MAIN_IDLE: begin
          if (IN_Init) begin
            main_q    <= MAIN_EXPOSURE;
            exp_cnt_q <= count_time_q;
          end
        end
        MAIN_EXPOSURE: begin
          if (rd_start) begin
            main_q    <= MAIN_READOUT;
            exp_cnt_q <= '0;
          end else begin
            exp_cnt_q <= exp_cnt_q - CT_W'(1);
          end
        end
        MAIN_READOUT: begin
          if (rd_done) begin
            main_q <= MAIN_IDLE;
          end
        end
        default: begin
          main_q    <= MAIN_IDLE;
          exp_cnt_q <= '0;
        end
      endcase
    end
  end

  // Edge detectors track the buttons in every state; the setting itself only
  // moves in IDLE, and simultaneous edges cancel.
  always_ff @(posedge IN_Clock or negedge IN_Reset) begin
    if (!IN_Reset) begin
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
      count_time_q <= CT_DEFAULT;
    end else begin
      inc_q <= IN_Exp_increase;
      dec_q <= IN_Exp_decrease;
      if ((main_q == MAIN_IDLE) && (inc_edge != dec_edge)) begin
        if (inc_edge && (count_time_q < CT_MAX)) begin
          count_time_q <= count_time_q + CT_W'(1);
        end else if (dec_edge && (count_time_q > CT_MIN)) begin
          count_time_q <= count_time_q - CT_W'(1);
        end
      end
    end
  end

  re_readout_fsm #(
    .RD_CYCLES(RD_CYCLES)
  ) u_readout (
    .clk   (IN_Clock),
    .rst_n (IN_Reset),
    .start (rd_start),
    .done  (rd_done),
    .nre_1 (OUT_NRE_1),
    .nre_2 (OUT_NRE_2),
    .adc   (OUT_ADC),
    .state (OUT_RD_FSM),
    .timer (OUT_RD_timer)
  );

  always_comb begin
    OUT_Expose     = (main_q == MAIN_EXPOSURE);
    OUT_Erase      = (main_q == MAIN_IDLE);
    OUT_count_time = count_time_q;
    OUT_Main_FSM   = main_q;
  end

endmodule

// File: tb/tb_re_control.sv
// tb_re_control: scoreboard bench for re_control.
// Stimulus pushes expected observations tagged with the cycle in which they
// must appear; a monitor on the falling edge pops and compares them.
module tb_re_control;

  typedef struct packed {
    logic [4:0] ct;
    logic [1:0] mf;
    logic [2:0] rf;
    logic [1:0] rt;
    logic       nre1;
    logic       nre2;
    logic       adc;
    logic       expose;
    logic       erase;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    string       name;
    obs_t        val;
    obs_t        mask;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       init;
  logic       inc;
  logic       dec;
  logic       nre_1;
  logic       nre_2;
  logic       adc;
  logic       expose;
  logic       erase;
  logic [4:0] count_time;
  logic [1:0] main_fsm;
  logic [2:0] rd_fsm;
  logic [1:0] rd_timer;

  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;
  exp_t        sb[$];

  re_control #(
    .T_DEFAULT(10),
    .T_MIN    (2),
    .T_MAX    (30),
    .RD_CYCLES(2)
  ) dut (
    .IN_Clock       (clk),
    .IN_Reset       (rst_n),
    .IN_Init        (init),
    .IN_Exp_increase(inc),
    .IN_Exp_decrease(dec),
    .OUT_NRE_1      (nre_1),
    .OUT_NRE_2      (nre_2),
    .OUT_ADC        (adc),
    .OUT_Expose     (expose),
    .OUT_Erase      (erase),
    .OUT_count_time (count_time),
    .OUT_Main_FSM   (main_fsm),
    .OUT_RD_FSM     (rd_fsm),
    .OUT_RD_timer   (rd_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input logic [4:0] ct, input logic [1:0] mf,
                              input logic [2:0] rf, input logic [1:0] rt);
    obs_t o;
    o.ct     = ct;
    o.mf     = mf;
    o.rf     = rf;
    o.rt     = rt;
    o.nre1   = (rf != 3'd1);
    o.nre2   = (rf != 3'd4);
    o.adc    = (rf == 3'd2) || (rf == 3'd5);
    o.expose = (mf == 2'd1);
    o.erase  = (mf == 2'd0);
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("ct=%0d main=%b rd=%b t=%0d nre1=%b nre2=%b adc=%b exp=%b erase=%b",
                     o.ct, o.mf, o.rf, o.rt, o.nre1, o.nre2, o.adc, o.expose, o.erase);
  endfunction

  task automatic push_abs(input string nm, input int unsigned c, input obs_t v, input obs_t m);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.val  = v;
    e.mask = m;
    sb.push_back(e);
  endtask

  task automatic expect_full(input string nm, input int unsigned dt, input obs_t v);
    obs_t m;
    m = '1;
    push_abs(nm, cyc + dt, v, m);
  endtask

  task automatic expect_ct(input string nm, input int unsigned dt, input logic [4:0] ct);
    obs_t m;
    obs_t v;
    m    = '0;
    m.ct = '1;
    v    = '0;
    v.ct = ct;
    push_abs(nm, cyc + dt, v, m);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Init is driven at the falling edge of check cycle c0; the next rising edge
  // samples it.  Expected: 12 EXPOSURE cycles, 12 readout cycles, then IDLE.
  task automatic push_capture(input int unsigned c0, input logic [4:0] ct, input int unsigned last);
    logic [2:0] rf_tab[12] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3,
                               3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6};
    logic [1:0] rt_tab[12] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0,
                               2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    obs_t m;
    m = '1;
    for (int unsigned j = 1; j <= 12; j++)
      if (c0 + j <= last)
        push_abs($sformatf("expose_%0d", j), c0 + j, mk(ct, 2'd1, 3'd0, 2'd0), m);
    for (int unsigned j = 0; j < 12; j++)
      if (c0 + 13 + j <= last)
        push_abs($sformatf("readout_%0d", j), c0 + 13 + j, mk(ct, 2'd2, rf_tab[j], rt_tab[j]), m);
    if (c0 + 25 <= last)
      push_abs("back_to_idle", c0 + 25, mk(ct, 2'd0, 3'd0, 2'd0), m);
  endtask

  task automatic pulse(input logic i, input logic d, input logic [4:0] ct, input string nm);
    inc = i;
    dec = d;
    expect_ct(nm, 1, ct);
    tick();
    expect_ct({nm, "_held"}, 1, ct);
    tick();
    inc = 1'b0;
    dec = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    obs_t act;
    int   i;
    act = {count_time, main_fsm, rd_fsm, rd_timer, nre_1, nre_2, adc, expose, erase};
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (((act ^ sb[i].val) & sb[i].mask) != '0) begin
          errors++;
          $display("FAIL %s @cycle %0d: got {%s} expected {%s}",
                   sb[i].name, cyc, fmt(act & sb[i].mask), fmt(sb[i].val & sb[i].mask));
        end
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: stale expectation for cycle %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    logic [4:0]  e;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    init   = 1'b0;
    inc    = 1'b0;
    dec    = 1'b0;

    // Reset held for 3 cycles, then released.
    tick();
    expect_full("reset_hold", 1, mk(5'd10, 2'd0, 3'd0, 2'd0));
    tick();
    tick();
    rst_n = 1'b1;
    expect_full("reset_exit", 1, mk(5'd10, 2'd0, 3'd0, 2'd0));
    tick();

    // Adjust in IDLE.
    pulse(1'b1, 1'b0, 5'd11, "inc1");
    pulse(1'b1, 1'b0, 5'd12, "inc2");
    pulse(1'b1, 1'b0, 5'd13, "inc3");
    pulse(1'b1, 1'b0, 5'd14, "inc4");
    pulse(1'b0, 1'b1, 5'd13, "dec1");
    pulse(1'b0, 1'b1, 5'd12, "dec2");

    // Saturation at both ends and simultaneous edges.
    e = 5'd12;
    for (int unsigned k = 0; k < 25; k++) begin
      e = (e < 5'd30) ? e + 5'd1 : 5'd30;
      pulse(1'b1, 1'b0, e, $sformatf("sat_inc%0d", k));
    end
    pulse(1'b1, 1'b1, 5'd30, "both_at_max");
    for (int unsigned k = 0; k < 35; k++) begin
      e = (e > 5'd2) ? e - 5'd1 : 5'd2;
      pulse(1'b0, 1'b1, e, $sformatf("sat_dec%0d", k));
    end
    pulse(1'b1, 1'b1, 5'd2, "both_at_min");
    for (int unsigned k = 0; k < 10; k++) begin
      e = e + 5'd1;
      pulse(1'b1, 1'b0, e, $sformatf("setup_inc%0d", k));
    end
    pulse(1'b1, 1'b1, 5'd12, "both_mid");

    // Capture with T=12, Init high one cycle.
    c0 = cyc;
    init = 1'b1;
    push_capture(c0, 5'd12, c0 + 25);
    tick();
    init = 1'b0;
    repeat (26) tick();

    // Requests during EXPOSURE/READOUT are ignored; Init still high on the
    // return to IDLE starts a second capture on the following edge.
    c0 = cyc;
    init = 1'b1;
    push_capture(c0, 5'd12, c0 + 25);
    push_capture(c0 + 25, 5'd12, c0 + 50);
    for (int unsigned d = 1; d <= 26; d++) begin
      tick();
      init = ((d >= 5) && (d <= 6)) || ((d >= 18) && (d <= 25));
      inc  = ((d >= 3) && (d <= 4)) || ((d >= 14) && (d <= 15));
      dec  = ((d >= 8) && (d <= 9)) || ((d >= 20) && (d <= 21));
    end
    repeat (26) tick();

    // Reset asserted mid-cycle during ADC_1.
    c0 = cyc;
    init = 1'b1;
    push_capture(c0, 5'd12, c0 + 16);
    tick();
    init = 1'b0;
    repeat (15) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push_abs("midreset", cyc, mk(5'd10, 2'd0, 3'd0, 2'd0), '1);
    tick();
    rst_n = 1'b1;
    expect_full("after_midreset", 1, mk(5'd10, 2'd0, 3'd0, 2'd0));
    tick();
    expect_full("idle_settled", 1, mk(5'd10, 2'd0, 3'd0, 2'd0));
    repeat (3) tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
